// File: rtl/relu_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : relu_channel_arbiter
// Description : Round-robin arbiter sharing one registered ReLU stage among
//               NUM_CH convolution output lanes, with per-lane element
//               counting and frame sequencing (IDLE/RUN/DRAIN/DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module relu_channel_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 13,
  parameter int FRAME_LEN = 676,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CH_W-1:0]   rr;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] lane_full;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic              slot_free;
  logic              transfer;
  logic [DATA_W-1:0] sample;

  // A lane stops competing once it has delivered its full frame
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign eligible[i]  = in_valid[i] && (cnt[i] < FRAME_MAX);
    assign lane_full[i] = (cnt[i] == FRAME_MAX);
  end

  // Output register can take a new word if empty or being drained this cycle
  assign slot_free = !out_valid || out_ready;

  // Round-robin pick: lowest eligible lane at/above rr, else lowest eligible lane overall (wrap)
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i] && (i >= int'(rr))) begin
        grant_idx = CH_W'(i);
      end
    end
  end

  assign transfer = (state == S_RUN) && slot_free && grant_found;
  assign sample   = in_data[grant_idx*DATA_W +: DATA_W];

  // One-hot ready toward the granted lane only
  always_comb begin
    in_ready = '0;
    if (transfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: frame runs until every lane is full, then waits for the held word to leave
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (&lane_full) state_nxt = S_DRAIN;
      S_DRAIN: if (!out_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Per-lane element counters, cleared when a frame starts; grants never exceed FRAME_LEN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if ((state == S_IDLE) && start) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (transfer) begin
      cnt[grant_idx] <= cnt[grant_idx] + CNT_W'(1);
    end
  end

  // Round-robin pointer moves just past the lane that transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (transfer) begin
      rr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // Registered ReLU output stage: load on transfer, clear valid on a bare handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= sample[DATA_W-1] ? '0 : sample;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
